// File: rtl/npu_ldst_pkg.sv
// Shared types for the rf_ldst descriptor scheduler.
// Contents:
//   RF_ADDR_W / LINE_NUM_W / TAG_W  descriptor field widths
//   ldst_desc_t                     one queued load/store descriptor
//   sched_state_t                   sequencer FSM states
//   desc_is_null()                  true for a descriptor with no lines to move
package npu_ldst_pkg;

    localparam int unsigned RF_ADDR_W  = 10;
    localparam int unsigned LINE_NUM_W = 11;
    localparam int unsigned TAG_W      = 4;

    typedef struct packed {
        logic                  is_store;
        logic [31:0]           sdram_addr;
        logic [RF_ADDR_W-1:0]  rf_addr;
        logic [LINE_NUM_W-1:0] line_num;
        logic [TAG_W-1:0]      tag;
    } ldst_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CPL,
        REJECT
    } sched_state_t;

    // A zero-line descriptor is never sent to the engine; it completes with an error.
    function automatic logic desc_is_null(input ldst_desc_t d);
        return d.line_num == '0;
    endfunction

endpackage

// File: rtl/rf_ldst_sched_if.sv
// Bus bundle between the control unit, the scheduler and the rf_ldst engine.
// Groups:
//   cmd_*  descriptor push from the control unit (valid/ready)
//   eng_*  start pulses and descriptor fields to rf_ldst, eng_done level back
//   cpl_*  single-cycle tagged completion, no backpressure
// Modports: master = control unit / engine side, slave = scheduler.
interface rf_ldst_sched_if;
    import npu_ldst_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_is_store;
    logic [31:0]           cmd_sdram_addr;
    logic [RF_ADDR_W-1:0]  cmd_rf_addr;
    logic [LINE_NUM_W-1:0] cmd_line_num;
    logic [TAG_W-1:0]      cmd_tag;

    logic                  eng_load_start;
    logic                  eng_store_start;
    logic [31:0]           eng_sdram_addr;
    logic [RF_ADDR_W-1:0]  eng_rf_addr;
    logic [LINE_NUM_W-1:0] eng_line_num;
    logic                  eng_done;

    logic                  cpl_valid;
    logic [TAG_W-1:0]      cpl_tag;
    logic                  cpl_err;

    modport master (
        output cmd_valid, cmd_is_store, cmd_sdram_addr, cmd_rf_addr, cmd_line_num, cmd_tag,
        input  cmd_ready,
        input  eng_load_start, eng_store_start, eng_sdram_addr, eng_rf_addr, eng_line_num,
        output eng_done,
        input  cpl_valid, cpl_tag, cpl_err
    );

    modport slave (
        input  cmd_valid, cmd_is_store, cmd_sdram_addr, cmd_rf_addr, cmd_line_num, cmd_tag,
        output cmd_ready,
        output eng_load_start, eng_store_start, eng_sdram_addr, eng_rf_addr, eng_line_num,
        input  eng_done,
        output cpl_valid, cpl_tag, cpl_err
    );

endinterface

// File: rtl/ldst_desc_fifo.sv
// Synchronous FIFO of ldst_desc_t, no write-to-read bypass.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  write request; ignored while full
//   pop          read request; ignored while empty
//   rdata        current head entry (valid while !empty)
//   full, empty  occupancy flags
//   level        occupancy 0..DEPTH
module ldst_desc_fifo
    import npu_ldst_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  ldst_desc_t              wdata,
    input  logic                    pop,
    output ldst_desc_t              rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);

    ldst_desc_t    mem [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rf_ldst_sched.sv
// Descriptor queue and sequencer for the rf_ldst engine.
// Descriptors pushed by the control unit are queued, issued one at a time to
// rf_ldst, and each posts a tagged completion once the engine is idle again.
// Zero-line descriptors are rejected without touching the engine.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (queue discarded)
//   sched_en    1 = may issue the next descriptor; a running op always finishes
//   bus         cmd_* push, eng_* engine control, cpl_* completion (slave view)
//   busy        queue non-empty or an op in flight
//   q_level     queue occupancy 0..DEPTH
module rf_ldst_sched
    import npu_ldst_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sched_en,
    rf_ldst_sched_if.slave          bus,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  q_level
);

    sched_state_t state_q, state_d;
    ldst_desc_t   cur_q, cur_d;
    ldst_desc_t   head;
    ldst_desc_t   wr_desc;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;

    always_comb begin
        wr_desc            = '0;
        wr_desc.is_store   = bus.cmd_is_store;
        wr_desc.sdram_addr = bus.cmd_sdram_addr;
        wr_desc.rf_addr    = bus.cmd_rf_addr;
        wr_desc.line_num   = bus.cmd_line_num;
        wr_desc.tag        = bus.cmd_tag;
    end

    ldst_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.cmd_valid),
        .wdata (wr_desc),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (q_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // Only pop once the engine reports idle, so ops never overlap.
                if (sched_en && !fifo_empty && bus.eng_done) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    state_d = desc_is_null(head) ? REJECT : ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT: begin
                // The engine drops eng_done on the edge that takes the start pulse.
                if (bus.eng_done) begin
                    state_d = CPL;
                end
            end
            CPL:     state_d = IDLE;
            REJECT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fields come from the registered descriptor, so they hold steady until
    // the next pop regardless of what the queue head does.
    assign bus.eng_sdram_addr  = cur_q.sdram_addr;
    assign bus.eng_rf_addr     = cur_q.rf_addr;
    assign bus.eng_line_num    = cur_q.line_num;
    assign bus.eng_load_start  = (state_q == ISSUE) && !cur_q.is_store;
    assign bus.eng_store_start = (state_q == ISSUE) && cur_q.is_store;

    assign bus.cpl_valid = (state_q == CPL) || (state_q == REJECT);
    assign bus.cpl_err   = (state_q == REJECT);
    assign bus.cpl_tag   = bus.cpl_valid ? cur_q.tag : '0;

    assign bus.cmd_ready = !fifo_full;
    assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_rf_ldst_sched.sv
// Directed bench for rf_ldst_sched with a behavioural rf_ldst engine model.
module tb_rf_ldst_sched;
    import npu_ldst_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sched_en = 1'b0;
    logic          busy;
    logic [LW-1:0] q_level;

    rf_ldst_sched_if bus ();

    rf_ldst_sched #(
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_en (sched_en),
        .bus      (bus),
        .busy     (busy),
        .q_level  (q_level)
    );

    always #5 clk = ~clk;

    // Engine model: goes busy on the edge that takes a start, idle again 20 edges later.
    logic [7:0] eng_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.eng_done <= 1'b1;
            eng_cnt      <= '0;
        end else if (bus.eng_load_start || bus.eng_store_start) begin
            bus.eng_done <= 1'b0;
            eng_cnt      <= 8'd19;
        end else if (!bus.eng_done) begin
            if (eng_cnt == 0) bus.eng_done <= 1'b1;
            else              eng_cnt <= eng_cnt - 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic                  is_store;
        logic [31:0]           addr;
        logic [RF_ADDR_W-1:0]  rf;
        logic [LINE_NUM_W-1:0] lines;
        int                    cyc;
    } st_rec_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [31:0]      addr;
        int               cyc;
    } cp_rec_t;

    st_rec_t st_q[$];
    cp_rec_t cp_q[$];
    int      both_cnt = 0;

    always @(negedge clk) begin
        if (bus.eng_load_start || bus.eng_store_start) begin
            st_q.push_back('{bus.eng_store_start, bus.eng_sdram_addr, bus.eng_rf_addr,
                             bus.eng_line_num, cyc});
        end
        if (bus.eng_load_start && bus.eng_store_start) both_cnt <= both_cnt + 1;
        if (bus.cpl_valid) begin
            cp_q.push_back('{bus.cpl_tag, bus.cpl_err, bus.eng_sdram_addr, cyc});
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [31:0] a, input logic [RF_ADDR_W-1:0] rf,
                        input logic [LINE_NUM_W-1:0] ln, input logic [TAG_W-1:0] tg);
        bit ok;
        ok                 = 1'b0;
        bus.cmd_valid      = 1'b1;
        bus.cmd_is_store   = st;
        bus.cmd_sdram_addr = a;
        bus.cmd_rf_addr    = rf;
        bus.cmd_line_num   = ln;
        bus.cmd_tag        = tg;
        for (int i = 0; i < 100; i++) begin
            if (bus.cmd_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        check($sformatf("push_accept_tag%0d", tg), ok, 1);
    endtask

    task automatic wait_cpl(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (cp_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, cp_q.size() >= n, 1);
    endtask

    task automatic wait_start(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (st_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(name, st_q.size() >= n, 1);
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, bus.cmd_ready, 1);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_q_level"}, q_level, 0);
        check({pfx, "_load_start"}, bus.eng_load_start, 0);
        check({pfx, "_store_start"}, bus.eng_store_start, 0);
        check({pfx, "_cpl_valid"}, bus.cpl_valid, 0);
        check({pfx, "_cpl_err"}, bus.cpl_err, 0);
        check({pfx, "_cpl_tag"}, bus.cpl_tag, 0);
        check({pfx, "_eng_sdram_addr"}, bus.eng_sdram_addr, 0);
        check({pfx, "_eng_rf_addr"}, bus.eng_rf_addr, 0);
        check({pfx, "_eng_line_num"}, bus.eng_line_num, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int bs, bc, c0;
        bus.cmd_valid      = 1'b0;
        bus.cmd_is_store   = 1'b0;
        bus.cmd_sdram_addr = '0;
        bus.cmd_rf_addr    = '0;
        bus.cmd_line_num   = '0;
        bus.cmd_tag        = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("reset");

        // Single load.
        sched_en = 1'b1;
        push(1'b0, 32'h1000, 10'd5, 11'd3, 4'd2);
        wait_cpl(1, 100, "t1_cpl_timeout");
        check("t1_starts", st_q.size(), 1);
        check("t1_is_store", st_q[0].is_store, 0);
        check("t1_sdram", st_q[0].addr, 32'h1000);
        check("t1_rf", st_q[0].rf, 5);
        check("t1_lines", st_q[0].lines, 3);
        check("t1_tag", cp_q[0].tag, 2);
        check("t1_err", cp_q[0].err, 0);
        check("t1_latency", cp_q[0].cyc - st_q[0].cyc, 22);
        check("t1_field_hold", cp_q[0].addr, 32'h1000);
        tick();

        // Fill to DEPTH with issue held, then a fifth push waits for the first pop.
        bs = st_q.size();
        bc = cp_q.size();
        sched_en = 1'b0;
        push(1'b0, 32'h2000, 10'd16, 11'd4, 4'd8);
        push(1'b1, 32'h3000, 10'd32, 11'd1, 4'd9);
        push(1'b0, 32'h4000, 10'd48, 11'd2, 4'd10);
        push(1'b1, 32'h5000, 10'd64, 11'd7, 4'd11);
        check("t2_ready_full", bus.cmd_ready, 0);
        check("t2_level_full", q_level, 4);
        check("t2_busy", busy, 1);
        sched_en = 1'b1;
        c0 = cyc;
        push(1'b0, 32'h6000, 10'd80, 11'd5, 4'd12);
        check("t2_fifth_wait", cyc - c0, 2);
        wait_cpl(bc + 5, 400, "t2_cpl_timeout");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_tag%0d", i), cp_q[bc + i].tag, 8 + i);
            check($sformatf("t2_err%0d", i), cp_q[bc + i].err, 0);
        end
        check("t2_starts", st_q.size(), bs + 5);
        check("t2_store_kind", st_q[bs + 1].is_store, 1);
        check("t2_store_addr", st_q[bs + 1].addr, 32'h3000);
        check("t2_last_lines", st_q[bs + 4].lines, 5);
        tick();

        // Zero-line store is rejected without an engine start.
        bs = st_q.size();
        bc = cp_q.size();
        push(1'b1, 32'h7000, 10'd3, 11'd0, 4'd7);
        c0 = cyc;
        wait_cpl(bc + 1, 10, "t3_cpl_timeout");
        check("t3_within3", (cp_q[bc].cyc - c0) <= 3, 1);
        check("t3_tag", cp_q[bc].tag, 7);
        check("t3_err", cp_q[bc].err, 1);
        repeat (5) tick();
        check("t3_no_start", st_q.size(), bs);
        check("t3_single_cpl", cp_q.size(), bc + 1);

        // Held queue of two, then released.
        bs = st_q.size();
        bc = cp_q.size();
        sched_en = 1'b0;
        push(1'b0, 32'h8000, 10'd1, 11'd2, 4'd3);
        push(1'b1, 32'h9000, 10'd2, 11'd1, 4'd4);
        repeat (10) tick();
        check("t4_no_start", st_q.size(), bs);
        check("t4_busy", busy, 1);
        check("t4_level", q_level, 2);
        sched_en = 1'b1;
        wait_cpl(bc + 2, 200, "t4_cpl_timeout");
        check("t4_tag0", cp_q[bc].tag, 3);
        check("t4_tag1", cp_q[bc + 1].tag, 4);
        check("t4_starts", st_q.size(), bs + 2);
        check("t4_kind1", st_q[bs + 1].is_store, 1);
        check("t4_spacing", (st_q[bs + 1].cyc - st_q[bs].cyc) >= 3, 1);
        tick();

        // sched_en dropped while A runs: A finishes, B waits.
        bs = st_q.size();
        bc = cp_q.size();
        push(1'b0, 32'hA000, 10'd6, 11'd2, 4'd5);
        push(1'b0, 32'hB000, 10'd7, 11'd2, 4'd6);
        wait_start(bs + 1, 20, "t5_start_timeout");
        tick();
        sched_en = 1'b0;
        wait_cpl(bc + 1, 100, "t5_a_cpl_timeout");
        check("t5_a_tag", cp_q[bc].tag, 5);
        repeat (10) tick();
        check("t5_b_held", st_q.size(), bs + 1);
        check("t5_level", q_level, 1);
        check("t5_busy", busy, 1);
        sched_en = 1'b1;
        wait_cpl(bc + 2, 100, "t5_b_cpl_timeout");
        check("t5_b_tag", cp_q[bc + 1].tag, 6);
        check("t5_b_addr", st_q[bs + 1].addr, 32'hB000);
        tick();

        // Reset in WAIT with three queued.
        bs = st_q.size();
        push(1'b1, 32'hC000, 10'd8, 11'd4, 4'd13);
        wait_start(bs + 1, 20, "t6_start_timeout");
        tick();
        push(1'b0, 32'hD000, 10'd9, 11'd1, 4'd14);
        push(1'b0, 32'hE000, 10'd10, 11'd1, 4'd15);
        push(1'b1, 32'hF000, 10'd11, 11'd1, 4'd1);
        check("t6_level", q_level, 3);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_in_reset");
        tick();
        tick();
        rst_n = 1'b1;
        bs = st_q.size();
        bc = cp_q.size();
        repeat (30) tick();
        check("t6_no_start", st_q.size(), bs);
        check("t6_no_cpl", cp_q.size(), bc);
        check_idle_outputs("t6_after");

        check("never_both_starts", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
